// File: rtl/dmem_responder.sv
// Fixed-latency tagged data-memory responder for a dcache: lowest-free-tag issue, in-order load returns.
// Define DMEM_STORE_ACK_EN to make stores hold their tag and return an acknowledge with the stored block.
module dmem_responder #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned MEM_LINES   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [63:0] proc2Dmem_data,
  output logic [3:0]  Dmem2proc_transaction_tag,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_data_tag,
  output logic [3:0]  outstanding_cnt
);

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NUM_TAGS = 2 ** TAG_W;
  localparam int unsigned IDX_W    = $clog2(MEM_LINES);
  localparam int unsigned CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned NUM_ENT  = (MEM_LATENCY > 1) ? MEM_LATENCY - 1 : 1;
  localparam int unsigned PTR_W    = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;

`ifdef DMEM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_command_t;

  logic [NUM_TAGS-1:0] busy;
  logic [NUM_TAGS-1:0] busy_next;
  logic [63:0]         mem [MEM_LINES];

  logic                ent_valid [NUM_ENT];
  logic [TAG_W-1:0]    ent_tag   [NUM_ENT];
  logic [63:0]         ent_data  [NUM_ENT];
  logic [CNT_W-1:0]    ent_cnt   [NUM_ENT];
  logic [PTR_W-1:0]    wr_ptr;

  logic                is_load;
  logic                is_store;
  logic                free_found;
  logic [TAG_W-1:0]    free_tag;
  logic                accept;
  logic                holds_tag;
  logic [IDX_W-1:0]    line_idx;
  logic [63:0]         resp_in;
  logic                unused_addr_bits;

  assign is_load   = (proc2Dmem_command == MEM_LOAD);
  assign is_store  = (proc2Dmem_command == MEM_STORE);
  assign line_idx  = proc2Dmem_addr[3 +: IDX_W];
  assign unused_addr_bits = ^{proc2Dmem_addr[2:0], proc2Dmem_addr[31:3+IDX_W]};

  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int unsigned i = 1; i < NUM_TAGS; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_tag   = TAG_W'(i);
      end
    end
  end

  assign accept    = !reset && free_found && (is_load || is_store);
  assign holds_tag = is_load || (is_store && STORE_ACK);
  assign Dmem2proc_transaction_tag = accept ? free_tag : '0;
  assign resp_in   = is_load ? mem[line_idx] : proc2Dmem_data;

  // The responding tag stays busy through its response cycle and frees at the edge closing it.
  always_comb begin
    busy_next = busy;
    if (Dmem2proc_data_tag != '0) busy_next[Dmem2proc_data_tag] = 1'b0;
    if (accept && holds_tag)      busy_next[free_tag] = 1'b1;
  end

  always_comb begin
    outstanding_cnt = '0;
    for (int unsigned i = 1; i < NUM_TAGS; i++) begin
      outstanding_cnt = outstanding_cnt + TAG_W'(busy[i]);
    end
  end

  // One acceptance per cycle at fixed latency lets entries be reused round-robin:
  // a slot is written on the same edge its previous occupant moves to the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy               <= '0;
      wr_ptr             <= '0;
      Dmem2proc_data_tag <= '0;
      Dmem2proc_data     <= '0;
      for (int unsigned i = 0; i < MEM_LINES; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
      for (int unsigned e = 0; e < NUM_ENT; e++) begin
        ent_valid[PTR_W'(e)] <= 1'b0;
        ent_tag[PTR_W'(e)]   <= '0;
        ent_data[PTR_W'(e)]  <= '0;
        ent_cnt[PTR_W'(e)]   <= '0;
      end
    end else begin
      busy               <= busy_next;
      wr_ptr             <= (wr_ptr == PTR_W'(NUM_ENT - 1)) ? '0 : wr_ptr + PTR_W'(1);
      Dmem2proc_data_tag <= '0;
      Dmem2proc_data     <= '0;

      for (int unsigned e = 0; e < NUM_ENT; e++) begin
        if (ent_valid[PTR_W'(e)]) begin
          if (ent_cnt[PTR_W'(e)] == CNT_W'(1)) begin
            Dmem2proc_data_tag   <= ent_tag[PTR_W'(e)];
            Dmem2proc_data       <= ent_data[PTR_W'(e)];
            ent_valid[PTR_W'(e)] <= 1'b0;
          end else begin
            ent_cnt[PTR_W'(e)] <= ent_cnt[PTR_W'(e)] - CNT_W'(1);
          end
        end
      end

      if (accept && holds_tag) begin
        if (MEM_LATENCY == 1) begin
          Dmem2proc_data_tag <= free_tag;
          Dmem2proc_data     <= resp_in;
        end else begin
          ent_valid[wr_ptr] <= 1'b1;
          ent_tag[wr_ptr]   <= free_tag;
          ent_data[wr_ptr]  <= resp_in;
          ent_cnt[wr_ptr]   <= CNT_W'(MEM_LATENCY - 1);
        end
      end

      if (accept && is_store) mem[line_idx] <= proc2Dmem_data;
    end
  end

endmodule
